// File: rtl/arb_requester.sv
// arb_requester: per-client pending counters driving an arbiter request vector;
// defining ARB_REQUESTER_STARVE_EN adds per-client wait counters and sticky starve flags.
module arb_requester #(
    parameter int CLIENTS  = 32,
    parameter int CNT_W    = 4,
    parameter int MAX_WAIT = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CLIENTS-1:0] push,
    output logic [CLIENTS-1:0] full,
    output logic [CLIENTS-1:0] request,
    input  logic [CLIENTS-1:0] grant,
    input  logic               stall,
    output logic [CLIENTS-1:0] served,
    output logic [31:0]        served_total,
    output logic [CLIENTS-1:0] overflow_err,
    output logic               spurious_err,
    output logic [CLIENTS-1:0] starve
);
    logic [CLIENTS-1:0][CNT_W-1:0] pending_q, pending_d;
    logic [CLIENTS-1:0] served_q, served_d, overflow_q, overflow_d, consume, accept;
    logic [31:0] served_total_q, served_total_d;
    logic spurious_q, spurious_d;

    always_comb begin
        full = '0;
        request = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            full[i] = pending_q[i] == '1;
            request[i] = pending_q[i] != '0;
        end
    end

    // full is taken pre-update, so a push on a full cycle is dropped even if that client is also consumed
    always_comb begin
        consume = grant & request & {CLIENTS{!stall}};
        accept = push & ~full;
        served_d = consume;
        overflow_d = overflow_q | (push & full);
        spurious_d = spurious_q | (!stall && ((grant & ~request) != '0 ||
                                              (grant & (grant - CLIENTS'(1))) != '0));
        served_total_d = served_total_q;
        pending_d = pending_q;
        for (int i = 0; i < CLIENTS; i++) begin
            served_total_d = served_total_d + 32'(consume[i]);
            pending_d[i] = accept[i] == consume[i] ? pending_q[i] :
                           accept[i] ? pending_q[i] + CNT_W'(1) : pending_q[i] - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
            served_q <= '0;
            served_total_q <= '0;
            overflow_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            served_q <= served_d;
            served_total_q <= served_total_d;
            overflow_q <= overflow_d;
            spurious_q <= spurious_d;
        end
    end

    assign served = served_q;
    assign served_total = served_total_q;
    assign overflow_err = overflow_q;
    assign spurious_err = spurious_q;

`ifdef ARB_REQUESTER_STARVE_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [CLIENTS-1:0][WAIT_W-1:0] age_q, age_d;
    logic [CLIENTS-1:0] starve_q, starve_d;

    always_comb begin
        age_d = age_q;
        starve_d = starve_q;
        for (int i = 0; i < CLIENTS; i++) begin
            age_d[i] = (!request[i] || consume[i]) ? '0 :
                       age_q[i] == WAIT_W'(MAX_WAIT) ? age_q[i] : age_q[i] + WAIT_W'(1);
            starve_d[i] = starve_q[i] | (age_d[i] == WAIT_W'(MAX_WAIT));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            age_q <= '0;
            starve_q <= '0;
        end else begin
            age_q <= age_d;
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    assign starve = '0;
`endif
endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side initiator for the round-robin arbiter: holds per-client pending-transaction counts and drives the arbiter's request vector.
- Consumes the arbiter's grant/stall and reports served transactions.
- By construction, a request bit that has not been granted stays asserted in the next cycle. The arbiter's request-stability constraint therefore holds at this interface.
- Sits between client push sources and the rr_arbiter request/grant ports.

Parameters:
- CLIENTS, 32, number of clients; width of all per-client vectors.
- CNT_W, 4, width of each pending counter; max pending per client = 2^CNT_W-1.
- MAX_WAIT, 64, starvation threshold in cycles (used only with the optional feature).

Ports:
- clock  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- push  input  CLIENTS  push[i]=1 adds one pending transaction for client i.
- full  output  CLIENTS  full[i]=1 when client i's pending count is at max.
- request  output  CLIENTS  to arbiter; request[i] = (pending[i] != 0).
- grant  input  CLIENTS  from arbiter.
- stall  input  1  from arbiter; when 1, grants this cycle are not consumed.
- served  output  CLIENTS  registered one-cycle pulse per consumed grant.
- served_total  output  32  count of consumed grants, wraps modulo 2^32.
- overflow_err  output  CLIENTS  sticky; push dropped because client was full.
- spurious_err  output  1  sticky; a grant arrived without request, or grant was multi-hot while stall=0.
- starve  output  CLIENTS  sticky starvation flags (optional feature only; otherwise tied 0).

Behaviour:
- Reset values: all pending counters, request, served, served_total, overflow_err, spurious_err and starve are 0. full is 0 after reset.
- Reset during operation discards all pending counts. request drops to 0 in the cycle after the reset sample.
- Consumed grant: consume[i] = grant[i] & request[i] & !stall.
- Accepted push: accept[i] = push[i] & !full[i].
- Pending update per client, per cycle:
  - accept only: +1.
  - consume only: -1.
  - both: unchanged.
  - neither: unchanged.
- Counters never wrap; saturation is enforced by dropping pushes while full.
- full[i] = (pending[i] == 2^CNT_W-1). It is combinational from the register.
- Simultaneous push and consume while full: push is still dropped, because full is evaluated pre-update. The count goes to max-1. overflow_err[i] is set.
- Latency:
  - push at cycle t (count 0) -> request[i] high at t+1.
  - consume at t with count 1 and no accept -> request[i] low at t+1.
- Stability: request[i] can only fall in the cycle after a consume of client i.
- served[i] = consume[i] registered, so it is high at t+1 for a consume at t.
- served_total increments by popcount(consume) each cycle (0..CLIENTS). The addition is 32-bit with wrap.
- grant[i] with request[i]=0 is ignored and sets spurious_err.
- Multi-hot grant with stall=0:
  - each bit is consumed independently if requested;
  - spurious_err is set.
- Grant while stall=1: nothing is consumed, no error is flagged, and pending is unchanged.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: ARB_REQUESTER_STARVE_EN.
- With the macro defined:
  - per-client wait counter of width clog2(MAX_WAIT+1);
  - it increments while request[i]=1 and consume[i]=0, saturating at MAX_WAIT;
  - it clears on consume[i] or when request[i]=0;
  - starve[i] is set (sticky) when the counter reaches MAX_WAIT.
- Without the macro: no wait counters are instantiated and starve is constant 0.

Test Plan:
- Reset, then push[3]=1 for 1 cycle -> request[3]=1 next cycle. Then grant[3]=1, stall=0 -> request[3]=0 and served[3]=1 the following cycle; served_total=1.
- Push client 5 three times (count 3), grant[5] with stall=1 for 2 cycles, then stall=0 for 3 cycles -> request[5] stays 1 through the stalls, drops after the third consume; served_total=3.
- Push client 0 sixteen times with CNT_W=4 -> full[0]=1 after 15; the 16th push is dropped and overflow_err[0]=1. Push plus grant on the same full cycle -> count 14, full[0]=0.
- grant[7]=1 with request[7]=0, and a separate cycle of grant=0x3 with request=0x3, stall=0 -> spurious_err=1, both clients consumed, served=0x3.
- Assert reset with clients 1, 2, 9 pending -> request=0 the cycle after the reset sample; all sticky flags are 0.
- With ARB_REQUESTER_STARVE_EN and MAX_WAIT=64: push client 4 and withhold grant 64 cycles -> starve[4]=1 and stays set after a later grant. Without the macro -> starve=0 throughout.
